transmitter: RTL and testbench
==============================

Name: transmitter

Overview:
- Serialises 40-bit monitor-interface frames onto `from_mon`. It is the outbound counterpart of the existing 40-bit `to_mon` receive path.
- Accepts words over a valid/ready handshake into a 2-entry FIFO and shifts each word out MSB-first behind a start bit. Each frame is followed by a fixed idle gap.
- Sits in `nextasic` between the audio/keyboard reply logic and the `from_mon` pin, replacing the constant-0 tie-off.

Parameters:
- FRAME_BITS, 40, payload bits per frame (matches the receive frame width).
- GAP_CYCLES, 8, `mon_clk` cycles of forced-low line after each frame's last data bit (must be >= 1).
- FIFO_DEPTH, 2, words buffered ahead of the shifter (must be >= 1).

Ports:
- mon_clk  input  1  monitor interface clock; the only clock.
- reset  input  1  synchronous, active-high reset.
- data  input  FRAME_BITS  word to transmit; bit 39 is sent first.
- data_valid  input  1  `data` is valid this cycle.
- data_ready  output  1  FIFO can accept a word.
- from_mon  output  1  serial line to the monitor; registered; idle low.
- busy  output  1  high while FSM is not IDLE or FIFO is non-empty.
- sent  output  1  one-cycle pulse when a frame's last data bit completes.

Behaviour:
- Reset (synchronous, active-high, sampled on the `mon_clk` rising edge):
  - `from_mon`=0, `sent`=0, `busy`=0.
  - FIFO emptied; FSM to IDLE; bit counter and gap counter cleared.
  - `data_ready`=0 while `reset` is high, 1 on the first cycle after release.
- Handshake:
  - A word transfers on an edge where `data_valid`&&`data_ready`.
  - `data_ready` = !fifo_full, driven from registered state only; no combinational path from `data_valid`.
  - When the FIFO is full, `data_ready`=0, even if a pop occurs in the same cycle (no pass-through).
  - `data` held while `data_valid`=1 && `data_ready`=0 is neither sampled nor lost.
- FSM states: IDLE, START, DATA, GAP.
  - IDLE: `from_mon`=0. If FIFO non-empty at the edge, pop head into a FRAME_BITS shift register, drive `from_mon`<=1, go to START.
  - A word pushed into an empty FIFO on edge E0 is popped at E1, so the start bit is visible E1..E2.
  - START (1 cycle): `from_mon`<=shift[MSB], shift left, bit counter=FRAME_BITS-1, go to DATA.
  - DATA: `from_mon` shows bits 39..0 on consecutive cycles E2..E42; each edge loads the next bit and decrements the counter.
  - On the edge that ends bit 0 (E42): `from_mon`<=0, `sent`<=1 for one cycle, gap counter=GAP_CYCLES-1, go to GAP.
  - GAP: `from_mon`=0. When the gap counter reaches 0: if the FIFO is non-empty, pop, drive the start bit and go to START; else go to IDLE.
  - Back-to-back frame period = 1+FRAME_BITS+GAP_CYCLES = 49 cycles at defaults, with no extra IDLE cycle.
- FIFO:
  - Circular buffer with read/write pointers of width `$clog2(FIFO_DEPTH)` that wrap modulo FIFO_DEPTH, plus an occupancy count of width `$clog2(FIFO_DEPTH+1)`.
  - A push and a pop in the same cycle leave the count unchanged.
  - A pop never occurs on an empty FIFO.
- Reset asserted mid-frame: `from_mon` is 0 from the next edge; the partial frame is truncated; queued words are discarded; `sent` is not pulsed.
- `busy` is registered-equivalent: it is 1 from the cycle after a push until the cycle after GAP exits to IDLE with an empty FIFO.
- No X on any output after reset, regardless of `data` contents.

Decomposition:
- Package `nextasic_pkg`:
  - Constants MON_FRAME_BITS=40 and MON_GAP_CYCLES=8, shared with the receive path.
  - Enum `tx_state_t` {IDLE, START, DATA, GAP}.
- One sub-module, `mon_tx_fifo`: parameterised-width/depth synchronous FIFO with push/pop/full/empty and synchronous active-high reset. The FSM and shifter stay in `transmitter`.

Test Plan:
- Single frame: after reset, push 40'hA5_0F_F0_5A_C3 at E0.
  - `from_mon`=1 at E1..E2, then the data bits MSB-first E2..E42.
  - `sent` pulses at E42; line low for 8 cycles; `busy`=0 afterwards.
- Back-to-back: push 40'h00_00_00_00_01 then 40'h80_00_00_00_00 on consecutive cycles.
  - Second start bit begins exactly 49 cycles after the first.
  - `data_ready` is 0 when the FIFO holds 2 words and never drops a word.
- Backpressure: hold `data_valid`=1 with three distinct words while the FIFO is full.
  - `data_ready`=0 until the first pop; all three frames are transmitted in order with correct bits.
- Reset mid-frame: assert `reset` for 1 cycle at bit 20 of a frame with 1 word queued.
  - `from_mon`=0 on the next edge and stays 0; `sent` never pulses; FIFO empty.
  - A fresh word afterwards transmits normally.
- Extreme payloads: 40'hFF_FF_FF_FF_FF and 40'h00_00_00_00_00.
  - The line reads 41 cycles high, then 8 low for all-ones; 1 high then 48 low for all-zeros.
  - A receiver instance looped back on `from_mon` reports the identical 40-bit word.

Source files
------------

// File: rtl/nextasic_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : nextasic_pkg                                               |
// | Brief   : Shared constants and types for the monitor interface       |
// |           receive and transmit paths.                                |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package nextasic_pkg;

    // Frame width shared by the to_mon receiver and the from_mon transmitter.
    localparam int MON_FRAME_BITS = 40;

    // Forced-low line cycles between consecutive outbound frames.
    localparam int MON_GAP_CYCLES = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        GAP   = 2'd3
    } tx_state_t;

endpackage
`default_nettype wire

// File: rtl/mon_tx_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : mon_tx_fifo                                                |
// | Brief   : Synchronous circular-buffer FIFO with occupancy count.     |
// |           Head word is presented on rd_data while not empty.         |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module mon_tx_fifo #(
    parameter int WIDTH = 40,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             push,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    // A depth of one still needs a one-bit pointer to index the storage.
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic [PTR_W-1:0] w_wr_ptr_next;
    logic [PTR_W-1:0] w_rd_ptr_next;

    assign w_wr_ptr_next = (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
    assign w_rd_ptr_next = (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + PTR_W'(1);

    assign full    = (r_count == CNT_W'(DEPTH));
    assign empty   = (r_count == '0);
    assign rd_data = r_mem[r_rd_ptr];

    // Storage is written only on push; its contents need no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    // Pointer and occupancy bookkeeping; simultaneous push and pop cancel.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) begin
                r_wr_ptr <= w_wr_ptr_next;
            end
            if (pop) begin
                r_rd_ptr <= w_rd_ptr_next;
            end
            case ({push, pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/transmitter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : transmitter                                                |
// | Brief   : Serialises monitor-interface frames onto from_mon: one     |
// |           start bit, FRAME_BITS data bits MSB-first, then a fixed    |
// |           low gap. Words arrive over valid/ready into a small FIFO.  |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module transmitter
    import nextasic_pkg::*;
#(
    parameter int FRAME_BITS = MON_FRAME_BITS,
    parameter int GAP_CYCLES = MON_GAP_CYCLES,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                  mon_clk,
    input  logic                  reset,
    input  logic [FRAME_BITS-1:0] data,
    input  logic                  data_valid,
    output logic                  data_ready,
    output logic                  from_mon,
    output logic                  busy,
    output logic                  sent
);

    localparam int BIT_CNT_W = $clog2(FRAME_BITS);
    localparam int GAP_CNT_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    tx_state_t             r_state;
    logic [FRAME_BITS-1:0] r_shift;
    logic [BIT_CNT_W-1:0]  r_bit_cnt;
    logic [GAP_CNT_W-1:0]  r_gap_cnt;

    logic                  w_fifo_full;
    logic                  w_fifo_empty;
    logic [FRAME_BITS-1:0] w_fifo_head;
    logic                  w_push;
    logic                  w_pop;

    // Ready depends only on FIFO occupancy (no pass-through on a same-cycle pop).
    assign data_ready = !w_fifo_full && !reset;
    assign w_push     = data_valid && data_ready;

    // A new frame may start from IDLE, or straight out of the last GAP cycle.
    assign w_pop = !w_fifo_empty &&
                   ((r_state == IDLE) || ((r_state == GAP) && (r_gap_cnt == '0)));

    assign busy = (r_state != IDLE) || !w_fifo_empty;

    mon_tx_fifo #(
        .WIDTH (FRAME_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (mon_clk),
        .rst     (reset),
        .wr_data (data),
        .push    (w_push),
        .pop     (w_pop),
        .rd_data (w_fifo_head),
        .full    (w_fifo_full),
        .empty   (w_fifo_empty)
    );

    // Frame sequencer: start bit, MSB-first shift-out, then the idle gap.
    always_ff @(posedge mon_clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_gap_cnt <= '0;
            from_mon  <= 1'b0;
            sent      <= 1'b0;
        end else begin
            sent <= 1'b0;
            case (r_state)
                IDLE: begin
                    from_mon <= 1'b0;
                    if (w_pop) begin
                        r_shift  <= w_fifo_head;
                        from_mon <= 1'b1;
                        r_state  <= START;
                    end
                end
                START: begin
                    from_mon  <= r_shift[FRAME_BITS-1];
                    r_shift   <= {r_shift[FRAME_BITS-2:0], 1'b0};
                    r_bit_cnt <= BIT_CNT_W'(FRAME_BITS - 1);
                    r_state   <= DATA;
                end
                DATA: begin
                    if (r_bit_cnt == '0) begin
                        from_mon  <= 1'b0;
                        sent      <= 1'b1;
                        r_gap_cnt <= GAP_CNT_W'(GAP_CYCLES - 1);
                        r_state   <= GAP;
                    end else begin
                        from_mon  <= r_shift[FRAME_BITS-1];
                        r_shift   <= {r_shift[FRAME_BITS-2:0], 1'b0};
                        r_bit_cnt <= r_bit_cnt - BIT_CNT_W'(1);
                    end
                end
                GAP: begin
                    from_mon <= 1'b0;
                    if (r_gap_cnt == '0) begin
                        if (w_pop) begin
                            r_shift  <= w_fifo_head;
                            from_mon <= 1'b1;
                            r_state  <= START;
                        end else begin
                            r_state <= IDLE;
                        end
                    end else begin
                        r_gap_cnt <= r_gap_cnt - GAP_CNT_W'(1);
                    end
                end
                default: begin
                    from_mon <= 1'b0;
                    r_state  <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_transmitter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_transmitter                                             |
// | Brief   : Self-checking bench for transmitter: single frames,        |
// |           back-to-back spacing, backpressure, mid-frame reset and    |
// |           extreme payloads, with a serial capture model on from_mon. |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module tb_transmitter;

    logic        mon_clk = 1'b0;
    logic        reset = 1'b1;
    logic [39:0] data = '0;
    logic        data_valid = 1'b0;
    logic        data_ready;
    logic        from_mon;
    logic        busy;
    logic        sent;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        logic [39:0] word;
        logic [39:0] exp_rx;
        int          exp_high;   // start bit plus number of one bits
    } vec_t;

    vec_t vecs[4];
    vec_t bp[5];

    transmitter dut (
        .mon_clk    (mon_clk),
        .reset      (reset),
        .data       (data),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .from_mon   (from_mon),
        .busy       (busy),
        .sent       (sent)
    );

    always #5 mon_clk = ~mon_clk;

    always @(posedge mon_clk) cyc <= cyc + 1;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge mon_clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Present one word and hold it until it is accepted; report stalled edges.
    task automatic push_word(input logic [39:0] w, output int stalls);
        logic rdy;
        data       = w;
        data_valid = 1'b1;
        stalls     = 0;
        while (1) begin
            rdy = data_ready;
            step();
            if (rdy) break;
            stalls++;
            if (stalls > 300) begin
                check("push timeout", 64'd0, 64'd1);
                break;
            end
        end
        data_valid = 1'b0;
    endtask

    // Wait for a start bit, capture 40 bits, verify the sent pulse and gap.
    task automatic expect_frame(input string name, input logic [39:0] exp,
                                input int exp_high, output int t_start);
        int          waited;
        int          highs;
        logic [39:0] rx;
        bit          quiet_data;
        bit          gap_low;
        waited  = 0;
        t_start = -1;
        while (from_mon !== 1'b1 && waited < 200) begin
            step();
            waited++;
        end
        if (from_mon !== 1'b1) begin
            check({name, " start timeout"}, 64'd0, 64'd1);
            return;
        end
        t_start    = cyc;
        rx         = '0;
        highs      = 1;
        quiet_data = 1'b1;
        for (int i = 0; i < 40; i++) begin
            step();
            rx = {rx[38:0], from_mon};
            if (from_mon === 1'b1) highs++;
            if (sent !== 1'b0) quiet_data = 1'b0;
        end
        step();
        check({name, " sent pulse"}, sent, 1'b1);
        gap_low = (from_mon === 1'b0);
        for (int i = 0; i < 7; i++) begin
            step();
            if (from_mon !== 1'b0 || sent !== 1'b0) gap_low = 1'b0;
        end
        check({name, " rx word"}, rx, exp);
        check({name, " high cycles"}, highs, exp_high);
        check({name, " no early sent"}, quiet_data, 1'b1);
        check({name, " gap low"}, gap_low, 1'b1);
    endtask

    initial begin
        int t0, t1, t2;
        int ts[5];
        int stalls[5];
        bit quiet;

        vecs[0] = '{40'hFF_FF_FF_FF_FF, 40'hFF_FF_FF_FF_FF, 41};
        vecs[1] = '{40'h00_00_00_00_00, 40'h00_00_00_00_00, 1};
        vecs[2] = '{40'hA5_0F_F0_5A_C3, 40'hA5_0F_F0_5A_C3, 21};
        vecs[3] = '{40'h00_00_00_00_01, 40'h00_00_00_00_01, 2};

        bp[0] = '{40'h11_22_33_44_55, 40'h11_22_33_44_55, 15};
        bp[1] = '{40'hDE_AD_BE_EF_01, 40'hDE_AD_BE_EF_01, 26};
        bp[2] = '{40'h0F_0F_0F_0F_0F, 40'h0F_0F_0F_0F_0F, 21};
        bp[3] = '{40'hC0_01_80_03_FF, 40'hC0_01_80_03_FF, 15};
        bp[4] = '{40'h5A_5A_5A_5A_5A, 40'h5A_5A_5A_5A_5A, 21};

        // Reset state
        reset = 1'b1;
        repeat (3) step();
        check("reset data_ready", data_ready, 1'b0);
        check("reset from_mon", from_mon, 1'b0);
        check("reset busy", busy, 1'b0);
        check("reset sent", sent, 1'b0);
        reset = 1'b0;
        #1;
        check("ready after release", data_ready, 1'b1);
        step();

        // Single frame with one-cycle pop latency
        data       = 40'hA5_0F_F0_5A_C3;
        data_valid = 1'b1;
        step();
        data_valid = 1'b0;
        t0 = cyc;
        check("busy after push", busy, 1'b1);
        check("line low at push edge", from_mon, 1'b0);
        expect_frame("single", 40'hA5_0F_F0_5A_C3, 21, t1);
        check("single start latency", t1 - t0, 1);
        step();
        check("single busy cleared", busy, 1'b0);

        // Back-to-back frames pushed on consecutive cycles
        data       = 40'h00_00_00_00_01;
        data_valid = 1'b1;
        step();
        data       = 40'h80_00_00_00_00;
        step();
        data_valid = 1'b0;
        check("b2b ready one word queued", data_ready, 1'b1);
        expect_frame("b2b first", 40'h00_00_00_00_01, 2, t1);
        expect_frame("b2b second", 40'h80_00_00_00_00, 2, t2);
        check("b2b frame period", t2 - t1, 49);
        step();
        check("b2b busy cleared", busy, 1'b0);

        // Backpressure: five words offered continuously
        fork
            begin
                for (int i = 0; i < 5; i++) push_word(bp[i].word, stalls[i]);
            end
            begin
                for (int i = 0; i < 5; i++)
                    expect_frame($sformatf("bp%0d", i), bp[i].exp_rx, bp[i].exp_high, ts[i]);
            end
        join
        check("bp word2 no stall", stalls[2], 0);
        check("bp word3 stall", stalls[3], 48);
        check("bp word4 stall", stalls[4], 48);
        for (int i = 1; i < 5; i++)
            check($sformatf("bp period %0d", i), ts[i] - ts[i-1], 49);
        step();
        check("bp busy cleared", busy, 1'b0);

        // Reset at bit 20 with one word queued behind the frame
        data       = 40'hF0_F0_F0_F0_F0;
        data_valid = 1'b1;
        step();
        data       = 40'h33_33_33_33_33;
        step();
        data_valid = 1'b0;
        check("rst start bit", from_mon, 1'b1);
        repeat (20) step();
        check("rst bit20 before reset", from_mon, 1'b1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        check("rst line low", from_mon, 1'b0);
        check("rst busy", busy, 1'b0);
        check("rst ready", data_ready, 1'b1);
        quiet = 1'b1;
        for (int i = 0; i < 60; i++) begin
            step();
            if (from_mon !== 1'b0 || sent !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
        end
        check("rst stays quiet", quiet, 1'b1);
        data       = 40'h12_34_56_78_9A;
        data_valid = 1'b1;
        step();
        data_valid = 1'b0;
        expect_frame("post reset", 40'h12_34_56_78_9A, 18, t1);
        step();
        check("post reset busy cleared", busy, 1'b0);

        // Table of payloads including the all-ones and all-zeros extremes
        for (int i = 0; i < 4; i++) begin
            data       = vecs[i].word;
            data_valid = 1'b1;
            step();
            data_valid = 1'b0;
            expect_frame($sformatf("vec%0d", i), vecs[i].exp_rx, vecs[i].exp_high, t1);
            step();
            check($sformatf("vec%0d busy cleared", i), busy, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
